// File: rtl/cmos_power_seq_pkg.sv
// Shared types and defaults for the OV5640 power-up / configuration sequencer.
package cmos_power_seq_pkg;

  // Encodings are visible on O_state, so the values are pinned.
  typedef enum logic [2:0] {
    StPwdn   = 3'd0,
    StPwrup  = 3'd1,
    StBoot   = 3'd2,
    StConfig = 3'd3,
    StRetry  = 3'd4,
    StWaitVs = 3'd5,
    StReady  = 3'd6,
    StFail   = 3'd7
  } seq_state_e;

  // Default cycle counts at 27 MHz.
  localparam int unsigned DefPwdnCycles       = 135_000;
  localparam int unsigned DefRstCycles        = 27_000;
  localparam int unsigned DefBootCycles       = 540_000;
  localparam int unsigned DefCfgTimeoutCycles = 27_000_000;
  localparam int unsigned DefMaxRetry         = 3;

  // Sensor/config pin levels driven in a given state.
  typedef struct packed {
    logic pwdn;
    logic rst_n;
    logic cfg_rst;
  } pin_t;

  localparam pin_t PinsReset = '{pwdn: 1'b1, rst_n: 1'b0, cfg_rst: 1'b1};

  function automatic pin_t pins_for(seq_state_e st);
    pin_t p;
    p = PinsReset;
    case (st)
      StPwrup:                    p = '{pwdn: 1'b0, rst_n: 1'b0, cfg_rst: 1'b1};
      StBoot:                     p = '{pwdn: 1'b0, rst_n: 1'b1, cfg_rst: 1'b1};
      StConfig, StWaitVs, StReady: p = '{pwdn: 1'b0, rst_n: 1'b1, cfg_rst: 1'b0};
      default:                    p = PinsReset;
    endcase
    return p;
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmos_vsync_edge.sv
// Brings raw camera vsync into the system clock domain and emits a one-cycle pulse on each
// rising edge of its active level.
module cmos_vsync_edge #(
  parameter bit VsPol = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vsync_i,
  output logic rise_o
);

  logic sync1_q, sync2_q, level_q, rise_q;
  logic active;

  // Normalise polarity so that 1 always means "vsync active".
  assign active = sync2_q ^ ~VsPol;

  // Two-flop synchroniser followed by a registered rising-edge detector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= vsync_i;
      sync2_q <= sync1_q;
      level_q <= active;
      rise_q  <= active & ~level_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/cmos_power_seq.sv
// OV5640 power-up / configuration sequencer: drives pwdn/reset pins with datasheet timing,
// gates i2c_config, supervises done/error with timeout and bounded retry, and declares the
// sensor ready after the first full frame.
module cmos_power_seq
  import cmos_power_seq_pkg::*;
#(
  parameter int unsigned PWDN_CYCLES        = DefPwdnCycles,
  parameter int unsigned RST_CYCLES         = DefRstCycles,
  parameter int unsigned BOOT_CYCLES        = DefBootCycles,
  parameter int unsigned CFG_TIMEOUT_CYCLES = DefCfgTimeoutCycles,
  parameter int unsigned MAX_RETRY          = DefMaxRetry,
  parameter bit          VS_POL             = 1'b1
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_restart,
  input  logic       I_cfg_done,
  input  logic       I_cfg_error,
  input  logic       I_cmos_vsync,
  output logic       O_cfg_rst,
  output logic       O_cmos_pwdn,
  output logic       O_cmos_rst_n,
  output logic       O_ready,
  output logic       O_fail,
  output logic [1:0] O_retry_cnt,
  output logic [2:0] O_state
);

  localparam int unsigned MaxCycles =
      max_u(max_u(PWDN_CYCLES, RST_CYCLES), max_u(BOOT_CYCLES, CFG_TIMEOUT_CYCLES));
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] PwdnLast    = CntW'(PWDN_CYCLES - 1);
  localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] BootLast    = CntW'(BOOT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(CFG_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]      MaxRetry    = 2'(MAX_RETRY);

  seq_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      retry_q, retry_d;
  logic            vs_seen_q, vs_seen_d;
  pin_t            pins_q;
  logic            ready_q, fail_q;
  logic            vs_rise;
  logic            timed;

  cmos_vsync_edge #(
    .VsPol (VS_POL)
  ) u_vsync_edge (
    .clk_i   (I_clk),
    .rst_ni  (I_rst_n),
    .vsync_i (I_cmos_vsync),
    .rise_o  (vs_rise)
  );

  // Next-state, retry bookkeeping and frame-edge counting.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    // The first vsync edge seen in WAIT_VS belongs to a partial frame; the flag is reset on
    // every other state so it starts clear on entry.
    vs_seen_d = (state_q == StWaitVs) ? vs_seen_q : 1'b0;
    case (state_q)
      StPwdn:   if (cnt_q == PwdnLast) state_d = StPwrup;
      StPwrup:  if (cnt_q == RstLast)  state_d = StBoot;
      StBoot:   if (cnt_q == BootLast) state_d = StConfig;
      StConfig: begin
        // Error takes priority over a simultaneous done.
        if (I_cfg_error)                state_d = StRetry;
        else if (I_cfg_done)            state_d = StWaitVs;
        else if (cnt_q == TimeoutLast)  state_d = StRetry;
      end
      StRetry: begin
        if (retry_q < MaxRetry) begin
          retry_d = retry_q + 2'd1;
          state_d = StPwdn;
        end else begin
          state_d = StFail;
        end
      end
      StWaitVs: begin
        if (vs_rise) begin
          if (vs_seen_q) state_d   = StReady;
          else           vs_seen_d = 1'b1;
        end
      end
      StReady, StFail: begin
        if (I_restart) begin
          state_d = StPwdn;
          retry_d = 2'd0;
        end
      end
      default: state_d = StPwdn;
    endcase
  end

  // Delay counter restarts at zero on every state entry and only runs in timed states.
  always_comb begin
    timed = (state_q == StPwdn) || (state_q == StPwrup) ||
            (state_q == StBoot) || (state_q == StConfig);
    if (state_d != state_q) cnt_d = '0;
    else if (timed)         cnt_d = cnt_q + CntW'(1);
    else                    cnt_d = '0;
  end

  // State, counters and registered outputs; pins track the state being entered, ready/fail
  // follow one cycle after the state.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q   <= StPwdn;
      cnt_q     <= '0;
      retry_q   <= 2'd0;
      vs_seen_q <= 1'b0;
      pins_q    <= PinsReset;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      vs_seen_q <= vs_seen_d;
      pins_q    <= pins_for(state_d);
      ready_q   <= (state_q == StReady);
      fail_q    <= (state_q == StFail);
    end
  end

  assign O_cmos_pwdn  = pins_q.pwdn;
  assign O_cmos_rst_n = pins_q.rst_n;
  assign O_cfg_rst    = pins_q.cfg_rst;
  assign O_ready      = ready_q;
  assign O_fail       = fail_q;
  assign O_retry_cnt  = retry_q;
  assign O_state      = state_q;

endmodule

// File: tb/tb_cmos_power_seq.sv
// Bench for cmos_power_seq: directed stimulus pushes the expected output snapshot and the
// cycle it must appear on; a monitor pops an entry on every observed output change.
module tb_cmos_power_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       restart = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cfg_error = 1'b0;
  logic       vsync = 1'b0;
  logic       cfg_rst, cmos_pwdn, cmos_rst_n, ready, fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  cmos_power_seq #(
    .PWDN_CYCLES        (10),
    .RST_CYCLES         (5),
    .BOOT_CYCLES        (20),
    .CFG_TIMEOUT_CYCLES (50),
    .MAX_RETRY          (2),
    .VS_POL             (1'b1)
  ) dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_restart    (restart),
    .I_cfg_done   (cfg_done),
    .I_cfg_error  (cfg_error),
    .I_cmos_vsync (vsync),
    .O_cfg_rst    (cfg_rst),
    .O_cmos_pwdn  (cmos_pwdn),
    .O_cmos_rst_n (cmos_rst_n),
    .O_ready      (ready),
    .O_fail       (fail),
    .O_retry_cnt  (retry_cnt),
    .O_state      (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Snapshot layout: {state[2:0], pwdn, rst_n, cfg_rst, ready, fail, retry[1:0]}
  typedef struct packed {
    int         cyc;   // -1 means any cycle
    logic [9:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic push(input int c, input logic [2:0] st, input logic pw, input logic rn,
                      input logic cr, input logic rd, input logic fl, input logic [1:0] rc);
    exp_t e;
    e.cyc = c;
    e.val = {st, pw, rn, cr, rd, fl, rc};
    sb_q.push_back(e);
  endtask

  // PWDN entered at cycle b: PWRUP, BOOT and CONFIG entries follow.
  task automatic push_seq(input int b, input logic [1:0] rc);
    push(b + 10, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rc);
    push(b + 15, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, rc);
    push(b + 35, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rc);
  endtask

  // Called at posedge+1; returns at posedge+1 once cyc has reached c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every output change against the head of the scoreboard.
  logic [9:0] obs;
  logic [9:0] prev_obs;
  exp_t       m_e;
  always @(negedge clk) begin
    obs = {state, cmos_pwdn, cmos_rst_n, cfg_rst, ready, fail, retry_cnt};
    if (obs !== prev_obs) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected: cyc %0d got %b, required no change", cyc, obs);
      end else begin
        m_e = sb_q.pop_front();
        if (obs !== m_e.val || (m_e.cyc >= 0 && cyc != m_e.cyc)) begin
          n_bad++;
          $display("FAIL evt%0d: cyc %0d got %b, required cyc %0d val %b",
                   n_vec, cyc, obs, m_e.cyc, m_e.val);
        end
      end
    end
    prev_obs = obs;
  end

  initial begin
    int r, b, c;
    // Reset values.
    push(-1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    goto(3);

    // Normal bring-up: done 40 cycles into CONFIG, two vsync pulses.
    r = cyc;
    push_seq(r, 2'd0);
    push(r + 75, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push(r + 94, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    push(r + 95, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    rst_n = 1'b1;
    goto(r + 74); cfg_done = 1'b1;
    goto(r + 75); cfg_done = 1'b0;
    goto(r + 80); vsync = 1'b1;
    goto(r + 83); vsync = 1'b0;
    goto(r + 90); vsync = 1'b1;
    goto(r + 93); vsync = 1'b0;

    // Restart from READY.
    goto(r + 100);
    c = cyc;
    push(c + 1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    push(c + 2, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    restart = 1'b1;
    goto(c + 1); restart = 1'b0;
    b = c + 1;

    // Error on every CONFIG: two retries, then FAIL.
    for (int k = 0; k < 3; k++) begin
      push_seq(b, 2'(k));
      push(b + 36, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'(k));
      if (k < 2) begin
        push(b + 37, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'(k + 1));
      end else begin
        push(b + 37, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        push(b + 38, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
      end
      goto(b + 35); cfg_error = 1'b1;
      goto(b + 36); cfg_error = 1'b0;
      b = b + 37;
    end

    // Restart from FAIL, restart in BOOT ignored, then CONFIG timeout.
    goto(b + 10);
    c = cyc;
    push(c + 1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    push(c + 2, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    restart = 1'b1;
    goto(c + 1); restart = 1'b0;
    b = c + 1;
    push_seq(b, 2'd0);
    push(b + 85, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    push(b + 86, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    goto(b + 20); restart = 1'b1;
    goto(b + 21); restart = 1'b0;
    goto(b + 86);
    b = b + 86;

    // done and error together: error wins.
    push_seq(b, 2'd1);
    push(b + 36, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    push(b + 37, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    goto(b + 35); cfg_done = 1'b1; cfg_error = 1'b1;
    goto(b + 36); cfg_done = 1'b0; cfg_error = 1'b0;
    b = b + 37;

    // Asynchronous reset in the middle of CONFIG, then a fresh bring-up.
    push_seq(b, 2'd2);
    goto(b + 40);
    c = cyc;
    push(c, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b0;
    goto(c + 1);
    r = cyc;
    push_seq(r, 2'd0);
    rst_n = 1'b1;
    goto(r + 45);

    // Every expected event must have been seen.
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending: %0d events left, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
